// File: rtl/lsu_bus_bridge.sv
// lsu_bus_bridge: turns the core's single-cycle load/store request into a
// valid/ready bus transaction. It stalls the core until the bus answers, and
// reports misalignment, bus error and timeout as a one-cycle fault in DONE.
module lsu_bus_bridge #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  // core side
  input  logic        dmem_req,
  input  logic        dmem_wr_en,
  input  logic [1:0]  dmem_size,
  input  logic        dmem_zero_extend,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wr_data,
  output logic [31:0] dmem_rd_data,
  output logic        dmem_stall,
  output logic        dmem_fault,
  // bus side
  output logic        bus_valid,
  input  logic        bus_ready,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_strb,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata,
  input  logic        bus_err
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  // The access expires in the cycle whose increment would make the counter
  // reach TIMEOUT_CYCLES, so exactly TIMEOUT_CYCLES cycles are spent in
  // ADDR+RESP and the counter reads TIMEOUT_CYCLES in DONE.
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_RESP, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          req_wr_q, req_wr_d;
  logic [1:0]    req_size_q, req_size_d;
  logic          req_zext_q, req_zext_d;
  logic [1:0]    req_lsb_q, req_lsb_d;
  logic          bus_valid_q, bus_valid_d;
  logic          bus_we_q, bus_we_d;
  logic [31:0]   bus_addr_q, bus_addr_d;
  logic [31:0]   bus_wdata_q, bus_wdata_d;
  logic [3:0]    bus_strb_q, bus_strb_d;
  logic [31:0]   rd_data_q, rd_data_d;
  logic          fault_q, fault_d;

  logic          misaligned;
  logic [31:0]   st_wdata;
  logic [3:0]    st_strb;
  logic [31:0]   ld_shift;
  logic [31:0]   ld_data;

  // Request decode: alignment check and store lane placement from live inputs
  always_comb begin
    misaligned = ((dmem_size == SZ_HALF) && dmem_addr[0]) ||
                 (dmem_size[1] && (dmem_addr[1:0] != 2'b00));
    unique case (dmem_size)
      SZ_BYTE: begin
        st_wdata = {4{dmem_wr_data[7:0]}};
        st_strb  = 4'b0001 << dmem_addr[1:0];
      end
      SZ_HALF: begin
        st_wdata = {2{dmem_wr_data[15:0]}};
        st_strb  = 4'b0011 << dmem_addr[1:0];
      end
      default: begin
        st_wdata = dmem_wr_data;
        st_strb  = 4'b1111;
      end
    endcase
  end

  // Load response: shift the addressed lane down, then extend to 32 bits
  always_comb begin
    ld_shift = bus_rdata >> {req_lsb_q, 3'b000};
    unique case (req_size_q)
      SZ_BYTE: ld_data = req_zext_q ? {24'h0, ld_shift[7:0]}
                                    : {{24{ld_shift[7]}}, ld_shift[7:0]};
      SZ_HALF: ld_data = req_zext_q ? {16'h0, ld_shift[15:0]}
                                    : {{16{ld_shift[15]}}, ld_shift[15:0]};
      default: ld_data = bus_rdata;
    endcase
  end

  // Next-state and next-output logic for the access FSM
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_wr_d    = req_wr_q;
    req_size_d  = req_size_q;
    req_zext_d  = req_zext_q;
    req_lsb_d   = req_lsb_q;
    bus_valid_d = bus_valid_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_strb_d  = bus_strb_q;
    rd_data_d   = rd_data_q;
    fault_d     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (dmem_req) begin
          req_wr_d   = dmem_wr_en;
          req_size_d = dmem_size;
          req_zext_d = dmem_zero_extend;
          req_lsb_d  = dmem_addr[1:0];
          if (misaligned) begin
            // Never reaches the bus; bus fields keep their last values.
            state_d = S_DONE;
            fault_d = 1'b1;
          end else begin
            state_d     = S_ADDR;
            cnt_d       = '0;
            bus_valid_d = 1'b1;
            bus_we_d    = dmem_wr_en;
            bus_addr_d  = {dmem_addr[31:2], 2'b00};
            bus_wdata_d = st_wdata;
            bus_strb_d  = dmem_wr_en ? st_strb : 4'b0000;
          end
        end
      end
      S_ADDR: begin
        cnt_d = cnt_q + CW'(1);
        // Expiry wins over a handshake landing in the same cycle.
        if (cnt_q == CNT_LAST) begin
          state_d     = S_DONE;
          bus_valid_d = 1'b0;
          fault_d     = 1'b1;
          if (!req_wr_q) rd_data_d = '0;
        end else if (bus_ready) begin
          state_d     = S_RESP;
          bus_valid_d = 1'b0;
        end
      end
      S_RESP: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
          fault_d = 1'b1;
          if (!req_wr_q) rd_data_d = '0;
        end else if (bus_rvalid) begin
          state_d = S_DONE;
          fault_d = bus_err;
          // Stores leave the load result register untouched.
          if (!req_wr_q) rd_data_d = ld_data;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs; reset returns everything to idle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      req_wr_q    <= 1'b0;
      req_size_q  <= 2'b00;
      req_zext_q  <= 1'b0;
      req_lsb_q   <= 2'b00;
      bus_valid_q <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_strb_q  <= 4'b0000;
      rd_data_q   <= '0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_wr_q    <= req_wr_d;
      req_size_q  <= req_size_d;
      req_zext_q  <= req_zext_d;
      req_lsb_q   <= req_lsb_d;
      bus_valid_q <= bus_valid_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_strb_q  <= bus_strb_d;
      rd_data_q   <= rd_data_d;
      fault_q     <= fault_d;
    end
  end

  assign dmem_stall   = dmem_req & (state_q != S_DONE) & ~reset;
  assign dmem_fault   = fault_q;
  assign dmem_rd_data = rd_data_q;
  assign bus_valid    = bus_valid_q;
  assign bus_we       = bus_we_q;
  assign bus_addr     = bus_addr_q;
  assign bus_wdata    = bus_wdata_q;
  assign bus_strb     = bus_strb_q;

endmodule

// File: tb/tb_lsu_bus_bridge.sv
// Bench for lsu_bus_bridge: directed literal cases plus randomized accesses
// checked every cycle against a transaction-level timeline model.
module tb_lsu_bus_bridge;

  localparam int T = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        dmem_req, dmem_wr_en, dmem_zero_extend;
  logic [1:0]  dmem_size;
  logic [31:0] dmem_addr, dmem_wr_data, dmem_rd_data;
  logic        dmem_stall, dmem_fault;
  logic        bus_valid, bus_ready, bus_we, bus_rvalid, bus_err;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_strb;

  always #5 clk = ~clk;

  lsu_bus_bridge #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset),
    .dmem_req(dmem_req), .dmem_wr_en(dmem_wr_en), .dmem_size(dmem_size),
    .dmem_zero_extend(dmem_zero_extend), .dmem_addr(dmem_addr),
    .dmem_wr_data(dmem_wr_data), .dmem_rd_data(dmem_rd_data),
    .dmem_stall(dmem_stall), .dmem_fault(dmem_fault),
    .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_strb(bus_strb),
    .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata), .bus_err(bus_err)
  );

  int n_vec = 0;
  int n_err = 0;

  // per-cycle expectations published by the stimulus side
  logic        chk_en = 1'b0;
  logic        e_stall, e_valid, e_we, e_fault;
  logic [31:0] e_addr, e_wdata, e_rd;
  logic [3:0]  e_strb;
  logic [31:0] m_rd;

  // observations from the last transaction, for literal checks
  logic [31:0] got_rd, got_addr, got_wdata;
  logic [3:0]  got_strb;
  logic        got_fault, got_we;
  int          got_stalls, got_valids;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Compare process: DUT outputs against the model on every checked cycle
  always @(negedge clk) begin
    if (chk_en) begin
      check("stall", 32'(dmem_stall), 32'(e_stall));
      check("bus_valid", 32'(bus_valid), 32'(e_valid));
      check("fault", 32'(dmem_fault), 32'(e_fault));
      check("rd_data", dmem_rd_data, e_rd);
      if (e_valid) begin
        check("bus_we", 32'(bus_we), 32'(e_we));
        check("bus_addr", bus_addr, e_addr);
        check("bus_strb", 32'(bus_strb), 32'(e_strb));
        if (e_we) check("bus_wdata", bus_wdata, e_wdata);
      end
    end
  end

  function automatic logic [31:0] ld_model(input logic [1:0] sz, input logic zx,
                                           input logic [1:0] a, input logic [31:0] w);
    logic [31:0] s;
    logic [31:0] r;
    s = w >> (8 * a);
    if (sz == 2'd0) begin
      r = s % 256;
      if (!zx && r >= 128) r = r + 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      r = s % 65536;
      if (!zx && r >= 32768) r = r + 32'hFFFF_0000;
    end else begin
      r = w;
    end
    return r;
  endfunction

  // One core access: cycle 0 is the IDLE request cycle; the bus raises ready
  // r cycles into ADDR and rvalid v cycles into RESP.
  task automatic run_txn(input logic wr, input logic [1:0] sz, input logic zx,
                         input logic [31:0] a, input logic [31:0] d, input int r,
                         input int v, input logic [31:0] rdata, input logic err,
                         input bit noise);
    int          done_c, valid_last;
    bit          misal, tmo;
    logic        flt;
    logic [31:0] wd, rd_exp;
    logic [3:0]  sb;
    misal = (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
    tmo = 1'b0;
    if (misal) begin
      done_c = 1; valid_last = 0;
    end else if (r + 1 + v <= T - 2) begin
      done_c = r + 3 + v; valid_last = r + 1;
    end else begin
      tmo = 1'b1; done_c = T + 1; valid_last = (r + 1 < T) ? r + 1 : T;
    end
    flt = misal || tmo || err;
    if (wr || misal) rd_exp = m_rd;
    else if (tmo)    rd_exp = 32'h0;
    else             rd_exp = ld_model(sz, zx, a[1:0], rdata);
    if (sz == 2'd0)      wd = (d % 256) * 32'h0101_0101;
    else if (sz == 2'd1) wd = (d % 65536) * 32'h0001_0001;
    else                 wd = d;
    if (!wr)             sb = 4'h0;
    else if (sz == 2'd0) sb = 4'(1 << a[1:0]);
    else if (sz == 2'd1) sb = 4'(3 << a[1:0]);
    else                 sb = 4'hF;
    got_stalls = 0; got_valids = 0;
    for (int c = 0; c <= done_c; c++) begin
      @(posedge clk); #1;
      dmem_req = 1'b1;
      if (c == 0) begin
        dmem_wr_en = wr; dmem_size = sz; dmem_zero_extend = zx;
        dmem_addr = a; dmem_wr_data = d;
      end else if (noise) begin
        dmem_wr_en = 1'($urandom); dmem_size = 2'($urandom_range(2));
        dmem_zero_extend = 1'($urandom); dmem_addr = $urandom; dmem_wr_data = $urandom;
      end
      bus_ready  = !misal && (c == r + 1);
      bus_rvalid = (c == r + 2 + v) ||
                   (noise && c >= 1 && c <= r + 1 && $urandom_range(1) == 1);
      bus_rdata  = (c == r + 2 + v) ? rdata : $urandom;
      bus_err    = (c == r + 2 + v) ? err : 1'($urandom);
      chk_en  = 1'b1;
      e_stall = (c < done_c);
      e_valid = (c >= 1 && c <= valid_last);
      e_we    = wr;
      e_addr  = {a[31:2], 2'b00};
      e_wdata = wd;
      e_strb  = sb;
      e_fault = (c == done_c) && flt;
      e_rd    = (c == done_c) ? rd_exp : m_rd;
      @(negedge clk);
      if (dmem_stall) got_stalls++;
      if (bus_valid)  got_valids++;
      if (c == done_c) begin
        got_rd = dmem_rd_data; got_fault = dmem_fault; got_addr = bus_addr;
        got_strb = bus_strb; got_wdata = bus_wdata; got_we = bus_we;
      end
    end
    m_rd = rd_exp;
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      dmem_req = 1'b0; bus_ready = 1'($urandom); bus_rvalid = 1'($urandom);
      bus_rdata = $urandom; bus_err = 1'($urandom);
      chk_en = 1'b1; e_stall = 1'b0; e_valid = 1'b0; e_fault = 1'b0; e_rd = m_rd;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    reset = 1'b1; dmem_req = 1'b0; dmem_wr_en = 1'b0; dmem_size = 2'd0;
    dmem_zero_extend = 1'b0; dmem_addr = '0; dmem_wr_data = '0;
    bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0; bus_err = 1'b0;
    m_rd = '0;
    #3;
    check("rst bus_valid", 32'(bus_valid), 32'd0);
    check("rst bus_addr", bus_addr, 32'd0);
    check("rst bus_wdata", bus_wdata, 32'd0);
    check("rst bus_strb", 32'(bus_strb), 32'd0);
    check("rst bus_we", 32'(bus_we), 32'd0);
    check("rst rd_data", dmem_rd_data, 32'd0);
    check("rst fault", 32'(dmem_fault), 32'd0);
    dmem_req = 1'b1; #1;
    check("rst stall masked", 32'(dmem_stall), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0; dmem_req = 1'b0;

    // aligned word load, minimum latency
    run_txn(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 0, 0, 32'hDEAD_BEEF, 1'b0, 1'b0);
    check("word ld rd", got_rd, 32'hDEAD_BEEF);
    check("word ld addr", got_addr, 32'h100);
    check("word ld fault", 32'(got_fault), 32'd0);
    check("word ld stalls", 32'(got_stalls), 32'd3);

    // byte loads from the top lane
    run_txn(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 0, 1, 32'h80FF_0000, 1'b0, 1'b0);
    check("byte sext", got_rd, 32'hFFFF_FF80);
    run_txn(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 1, 0, 32'h80FF_0000, 1'b0, 1'b0);
    check("byte zext", got_rd, 32'h0000_0080);

    // half store with a slow bus
    run_txn(1'b1, 2'd1, 1'b0, 32'h22, 32'h1234_ABCD, 4, 0, 32'h0, 1'b0, 1'b0);
    check("half st addr", got_addr, 32'h20);
    check("half st strb", 32'(got_strb), 32'hC);
    check("half st wdata", got_wdata, 32'hABCD_ABCD);
    check("half st we", 32'(got_we), 32'd1);
    check("half st rd kept", got_rd, 32'h0000_0080);
    check("half st valids", 32'(got_valids), 32'd5);

    // misaligned word load
    run_txn(1'b0, 2'd2, 1'b0, 32'h102, 32'h0, 0, 0, 32'h1111_1111, 1'b0, 1'b0);
    check("misal fault", 32'(got_fault), 32'd1);
    check("misal stalls", 32'(got_stalls), 32'd1);
    check("misal valids", 32'(got_valids), 32'd0);

    // timeout, ready never arrives
    run_txn(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 50, 0, 32'h5555_5555, 1'b0, 1'b0);
    check("tmo fault", 32'(got_fault), 32'd1);
    check("tmo rd", got_rd, 32'h0);
    check("tmo valids", 32'(got_valids), 32'd8);
    check("tmo stalls", 32'(got_stalls), 32'd9);

    // reset while waiting in RESP, then a late response
    @(posedge clk); #1;
    chk_en = 1'b0; dmem_req = 1'b1; dmem_wr_en = 1'b0; dmem_size = 2'd2;
    dmem_addr = 32'h200; bus_ready = 1'b0; bus_rvalid = 1'b0;
    @(posedge clk); #1; bus_ready = 1'b1;
    @(posedge clk); #1; bus_ready = 1'b0;
    #2; reset = 1'b1; #1;
    check("rstresp valid", 32'(bus_valid), 32'd0);
    check("rstresp stall", 32'(dmem_stall), 32'd0);
    check("rstresp addr", bus_addr, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0; dmem_req = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h1234_5678; bus_err = 1'b1;
    @(negedge clk);
    check("late rvalid fault", 32'(dmem_fault), 32'd0);
    check("late rvalid rd", dmem_rd_data, 32'd0);
    check("late rvalid valid", 32'(bus_valid), 32'd0);
    @(posedge clk); #1; bus_rvalid = 1'b0; m_rd = 32'h0;
    run_txn(1'b0, 2'd2, 1'b0, 32'h300, 32'h0, 0, 0, 32'hCAFE_F00D, 1'b0, 1'b0);
    check("post-rst rd", got_rd, 32'hCAFE_F00D);
    check("post-rst stalls", 32'(got_stalls), 32'd3);

    // randomized accesses
    for (int i = 0; i < 300; i++) begin
      logic [1:0]  sz;
      logic [31:0] a;
      int          r;
      sz = 2'($urandom_range(2));
      a  = $urandom;
      if ($urandom_range(3) != 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'b00;
      end
      r = ($urandom_range(9) == 0) ? 9 : int'($urandom_range(4));
      run_txn(1'($urandom), sz, 1'($urandom), a, $urandom, r, int'($urandom_range(4)),
              $urandom, ($urandom_range(7) == 0), 1'($urandom));
      idle_cycles(int'($urandom_range(2)));
    end

    @(posedge clk); #1; chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
